// File: rtl/truth_table_sweeper_if.sv
// Handshake/result bundle between the truth-table sweeper and the environment
// that hosts the two implementations under comparison.
interface truth_table_sweeper_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic            abort;
    logic            r_a;
    logic            r_b;
    logic [N_IN-1:0] vec;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   mism_cnt;
    logic [N_IN-1:0] first_bad;
    logic            first_valid;

    modport master (
        output start, abort, r_a, r_b,
        input  vec, busy, done, pass, mism_cnt, first_bad, first_valid
    );

    modport slave (
        input  start, abort, r_a, r_b,
        output vec, busy, done, pass, mism_cnt, first_bad, first_valid
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks every N_IN-bit input vector into two implementations of one boolean
// function, compares their outputs per vector and reports mismatch statistics.
module truth_table_sweeper #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    truth_table_sweeper_if.slave bus
);
    localparam int CNT_W = $clog2(SETTLE + 2);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [N_IN-1:0] vec_q;
    logic [CNT_W-1:0] cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [N_IN:0]   mism_q;
    logic [N_IN-1:0] first_bad_q;
    logic            first_valid_q;

    logic            miss_d;
    logic [N_IN:0]   mism_d;
    logic [N_IN-1:0] vec_d;
    logic            last_vec_d;

    always_comb begin
        miss_d     = bus.r_a ^ bus.r_b;
        mism_d     = mism_q + (N_IN + 1)'(miss_d);
        vec_d      = vec_q + N_IN'(1);
        last_vec_d = &vec_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            vec_q         <= '0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            mism_q        <= '0;
            first_bad_q   <= '0;
            first_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // abort has priority over a simultaneous start
                    if (bus.start && !bus.abort) begin
                        vec_q         <= '0;
                        busy_q        <= 1'b1;
                        mism_q        <= '0;
                        first_bad_q   <= '0;
                        first_valid_q <= 1'b0;
                        cnt_q         <= CNT_RELOAD;
                        state_q       <= (SETTLE == 0) ? S_SAMPLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q <= CNT_W'(1)) begin
                            state_q <= S_SAMPLE;
                        end
                    end
                end
                S_SAMPLE: begin
                    // an abort discards the comparison of the current vector
                    if (bus.abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else begin
                        if (miss_d) begin
                            mism_q <= mism_d;
                            if (!first_valid_q) begin
                                first_bad_q   <= vec_q;
                                first_valid_q <= 1'b1;
                            end
                        end
                        if (last_vec_d) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            pass_q  <= (mism_d == '0);
                        end else begin
                            vec_q   <= vec_d;
                            cnt_q   <= CNT_RELOAD;
                            state_q <= (SETTLE == 0) ? S_SAMPLE : S_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.vec         = vec_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.mism_cnt    = mism_q;
    assign bus.first_bad   = first_bad_q;
    assign bus.first_valid = first_valid_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench for truth_table_sweeper: two instances (N_IN=2/SETTLE=1 and
// N_IN=3/SETTLE=0) driven from random truth tables, scored by a table model.
module tb_truth_table_sweeper;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] fa = '0;
    logic [7:0] fb = '0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(2)) if0 ();
    truth_table_sweeper_if #(.N_IN(3)) if1 ();

    assign if0.start = start & ~sel;
    assign if0.abort = abort & ~sel;
    assign if0.r_a   = fa[if0.vec];
    assign if0.r_b   = fb[if0.vec];
    assign if1.start = start & sel;
    assign if1.abort = abort & sel;
    assign if1.r_a   = fa[if1.vec];
    assign if1.r_b   = fb[if1.vec];

    truth_table_sweeper #(.N_IN(2), .SETTLE(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    truth_table_sweeper #(.N_IN(3), .SETTLE(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    logic [2:0] o_vec, o_first_bad;
    logic [3:0] o_mism;
    logic       o_busy, o_done, o_pass, o_fv;

    always_comb begin
        o_vec       = sel ? if1.vec : {1'b0, if0.vec};
        o_first_bad = sel ? if1.first_bad : {1'b0, if0.first_bad};
        o_mism      = sel ? if1.mism_cnt : {1'b0, if0.mism_cnt};
        o_busy      = sel ? if1.busy : if0.busy;
        o_done      = sel ? if1.done : if0.done;
        o_pass      = sel ? if1.pass : if0.pass;
        o_fv        = sel ? if1.first_valid : if0.first_valid;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int nvec();
        return sel ? 8 : 4;
    endfunction

    function automatic int per_vec();
        return sel ? 1 : 2;
    endfunction

    // mismatches among the first c vectors of the truth table
    function automatic int mism_upto(input int c);
        int m = 0;
        for (int i = 0; i < c; i++) if (fa[i] != fb[i]) m++;
        return m;
    endfunction

    function automatic int first_upto(input int c);
        for (int i = 0; i < c; i++) if (fa[i] != fb[i]) return i;
        return 0;
    endfunction

    task automatic check_results(input string tag, input int c);
        chk({tag, "_mism"}, o_mism, mism_upto(c));
        chk({tag, "_fv"}, o_fv, (mism_upto(c) > 0) ? 1 : 0);
        chk({tag, "_fbad"}, o_first_bad, first_upto(c));
    endtask

    task automatic run_sweep(input bit hold_start, input bit abort_in_done);
        int n = 0;
        int verr = 0;
        int tot = nvec() * per_vec();
        bit exp_pass = (mism_upto(nvec()) == 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("accept_busy", o_busy, 1);
        chk("accept_clear", o_mism, 0);
        if (!hold_start) start = 1'b0;
        while (!o_done && n < tot + 20) begin
            if (o_vec != n / per_vec()) verr++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_latency", n, tot);
        chk("vec_sequence", verr, 0);
        chk("done_busy", o_busy, 0);
        chk("done_pass", o_pass, exp_pass ? 1 : 0);
        check_results("done", nvec());
        if (abort_in_done) abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("done_pulse_end", o_done, 0);
        chk("no_restart", o_busy, 0);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_pass", o_pass, exp_pass ? 1 : 0);
        chk("hold_vec", o_vec, nvec() - 1);
        check_results("hold", nvec());
    endtask

    task automatic run_abort(input int a);
        int c = (a - 1) / per_vec();
        int dcnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < a - 1; i++) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", o_busy, 0);
        chk("abort_pass", o_pass, 0);
        chk("abort_vec", o_vec, c);
        check_results("abort", c);
        for (int i = 0; i < nvec() * per_vec() + 4; i++) begin
            @(posedge clk);
            #1;
            if (o_done) dcnt++;
        end
        chk("abort_nodone", dcnt, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_vec", o_vec, 0);
        chk("rst_pass", o_pass, 0);
        chk("rst_done", o_done, 0);
        check_results("rst", 0);
        @(negedge clk);
        rst_n = 1'b1;

        // N_IN=2, SETTLE=1: matching, single mismatch at 10, always inverted
        fa = 8'($urandom);
        fb = fa;
        run_sweep(1'b0, 1'b0);
        fb = fa ^ 8'b0000_0100;
        run_sweep(1'b0, 1'b0);
        fb = ~fa;
        run_sweep(1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            fa = 8'($urandom);
            fb = ($urandom_range(0, 2) == 0) ? fa : 8'($urandom);
            run_sweep(1'($urandom), 1'($urandom));
        end

        // abort part-way, then a clean sweep must still pass
        for (int k = 0; k < 3; k++) begin
            fa = 8'($urandom);
            fb = 8'($urandom);
            run_abort((k == 0) ? 3 : int'($urandom_range(1, 7)));
            fb = fa;
            run_sweep(1'b0, 1'b0);
        end

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", o_busy, 0);

        // async reset mid-sweep with pass=1 carried from the previous sweep
        fa = 8'($urandom);
        fb = fa ^ 8'b0000_0001;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_vec", o_vec, 2);
        chk("mid_pass_kept", o_pass, 1);
        chk("mid_mism", o_mism, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", o_busy, 0);
        chk("arst_vec", o_vec, 0);
        chk("arst_pass", o_pass, 0);
        check_results("arst", 0);
        @(negedge clk);
        rst_n = 1'b1;

        // N_IN=3, SETTLE=0
        sel = 1'b1;
        fa = 8'($urandom);
        fb = fa;
        run_sweep(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            fa = 8'($urandom);
            fb = ($urandom_range(0, 2) == 0) ? fa : 8'($urandom);
            run_sweep(1'($urandom), 1'($urandom));
        end
        fb = ~fa;
        run_abort(int'($urandom_range(1, 7)));
        run_sweep(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=%0d expected=%0d", 0, 1);
        $fatal(1, "bench time limit");
    end
endmodule
